// File: rtl/oam_dma_controller.sv
// oam_dma_controller: $4014 sprite DMA sequencer.
// Halts the CPU, aligns to an even CPU cycle, then runs 256 read/write pairs
// that copy {page, $00..$FF} from the CPU bus into PPU OAM.
module oam_dma_controller #(
   parameter logic [15:0] TRIGGER_ADDR = 16'h4014
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ENABLE,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_out,
   input  logic        cpu_rw_n,
   input  logic [7:0]  mem_data_in,
   output logic        dma_active,
   output logic [15:0] dma_addr,
   output logic        dma_rden,
   output logic        oam_wren,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_data,
   output logic        dma_done
);

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

   state_t     state_q;
   logic       par_q;
   logic [7:0] page_q;
   logic [7:0] count_q;
   logic       done_q;
   logic       trigger;

   // A CPU write to the trigger address; only honoured from IDLE below.
   assign trigger = ENABLE & ~cpu_rw_n & (cpu_addr == TRIGGER_ADDR);

   // Sequencer: state, cycle parity, page/count and the done pulse. Everything holds while ENABLE is low.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         par_q   <= 1'b0;
         page_q  <= 8'h00;
         count_q <= 8'h00;
         done_q  <= 1'b0;
      end else if (ENABLE) begin
         par_q  <= ~par_q;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  page_q  <= cpu_data_out;
                  count_q <= 8'h00;
                  state_q <= HALT;
               end
            end
            // par_q = 1 here means the next cycle is even, so reads can start at once.
            HALT:  state_q <= par_q ? READ : ALIGN;
            ALIGN: state_q <= READ;
            READ:  state_q <= WRITE;
            WRITE: begin
               if (count_q == 8'hFF) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end else begin
                  // count is 8 bits: the source address never carries into the page byte.
                  count_q <= count_q + 8'd1;
                  state_q <= READ;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Strobes decode the current state; consumers qualify them with ENABLE.
   always_comb begin
      dma_active = (state_q != IDLE);
      dma_rden   = (state_q == READ);
      oam_wren   = (state_q == WRITE);
      dma_addr   = dma_rden ? {page_q, count_q} : 16'h0000;
      oam_addr   = oam_wren ? count_q : 8'h00;
      oam_data   = oam_wren ? mem_data_in : 8'h00;
   end

   assign dma_done = done_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller with a read/write scoreboard.
module tb_oam_dma_controller;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        ENABLE = 1'b1;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0]  cpu_data_out = 8'h00;
   logic        cpu_rw_n = 1'b1;
   logic [7:0]  mem_q = 8'h00;
   logic        dma_active, dma_rden, oam_wren, dma_done;
   logic [15:0] dma_addr;
   logic [7:0]  oam_addr, oam_data;

   int          checks = 0;
   int          errors = 0;
   int          act_cnt = 0;
   int          done_cnt = 0;
   logic        tpar = 1'b0;
   logic [31:0] rdq[$];
   logic [31:0] wq[$];

   always #5 CLK = ~CLK;

   oam_dma_controller #(.TRIGGER_ADDR(16'h4014)) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
      .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out), .cpu_rw_n(cpu_rw_n),
      .mem_data_in(mem_q),
      .dma_active(dma_active), .dma_addr(dma_addr), .dma_rden(dma_rden),
      .oam_wren(oam_wren), .oam_addr(oam_addr), .oam_data(oam_data),
      .dma_done(dma_done)
   );

   // Synchronous CPU-bus memory, one-cycle latency, pattern = addr ^ $5A.
   always @(posedge CLK) if (dma_rden) mem_q <= dma_addr[7:0] ^ 8'h5A;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock; tracks the parity the DUT should hold after the edge.
   task automatic cyc();
      logic r, e;
      r = RESET;
      e = ENABLE;
      @(posedge CLK);
      if (r) tpar = 1'b0;
      else if (e) tpar = ~tpar;
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_active"}, 32'(dma_active), 32'd0);
      chk({tag, "_rden"},   32'(dma_rden),   32'd0);
      chk({tag, "_wren"},   32'(oam_wren),   32'd0);
      chk({tag, "_addr"},   32'(dma_addr),   32'd0);
      chk({tag, "_oaddr"},  32'(oam_addr),   32'd0);
      chk({tag, "_odata"},  32'(oam_data),   32'd0);
      chk({tag, "_done"},   32'(dma_done),   32'd0);
   endtask

   // Per-cycle scoreboard compare for enabled bus activity.
   task automatic monitor();
      logic [31:0] exp;
      if (ENABLE && dma_active) act_cnt++;
      if (dma_done) done_cnt++;
      if (ENABLE && dma_rden) begin
         exp = (rdq.size() > 0) ? rdq.pop_front() : 32'hFFFF_FFFF;
         chk("rd_addr", 32'(dma_addr), exp);
      end
      if (ENABLE && oam_wren) begin
         exp = (wq.size() > 0) ? wq.pop_front() : 32'hFFFF_FFFF;
         chk("oam_wr", {16'h0, oam_addr, oam_data}, exp);
      end
   endtask

   // One transfer: hp = parity wanted in HALT, retrig_at = active cycle for a stray
   // trigger write (0 = none), rst_byte = reset during WRITE of that byte (-1 = none).
   task automatic xfer(input logic [7:0] pg, input logic hp, input int exp_len,
                       input int retrig_at, input int rst_byte, input bit frz);
      logic [7:0]  b;
      logic [15:0] saved;
      bit          fin, rst_hit, fdone;
      fin = 0; rst_hit = 0; fdone = 0;
      while (tpar == hp) cyc();
      cpu_addr = 16'h4014; cpu_data_out = pg; cpu_rw_n = 1'b0;
      for (int i = 0; i < 256; i++) begin
         b = i[7:0];
         rdq.push_back({16'h0, pg, b});
         wq.push_back({16'h0, b, b ^ 8'h5A});
      end
      cyc();
      cpu_rw_n = 1'b1; cpu_addr = 16'h0000;
      act_cnt = 0; done_cnt = 0;
      for (int k = 0; k < 700 && !fin && !rst_hit; k++) begin
         monitor();
         if (dma_done) fin = 1;
         else begin
            if (retrig_at > 0 && act_cnt == retrig_at) begin
               cpu_addr = 16'h4014; cpu_data_out = 8'h07; cpu_rw_n = 1'b0;
            end else begin
               cpu_addr = 16'h0000; cpu_rw_n = 1'b1;
            end
            if (frz && !fdone && dma_rden && act_cnt >= 200) begin
               saved = dma_addr;
               ENABLE = 1'b0;
               repeat (10) begin
                  cyc();
                  chk("frz_rden", 32'(dma_rden), 32'd1);
                  chk("frz_addr", 32'(dma_addr), 32'(saved));
               end
               ENABLE = 1'b1;
               fdone = 1;
            end
            if (rst_byte >= 0 && oam_wren && oam_addr == 8'(rst_byte)) begin
               RESET = 1'b1;
               cyc();
               RESET = 1'b0;
               rst_hit = 1;
            end else cyc();
         end
      end
      cpu_rw_n = 1'b1; cpu_addr = 16'h0000;
      if (rst_hit) begin
         chk_quiet("rst_mid");
         repeat (5) begin
            cyc();
            monitor();
         end
         chk("rst_no_done", 32'(done_cnt), 32'd0);
         chk("rst_no_act", 32'(act_cnt), 32'(act_cnt - 0));
         rdq.delete();
         wq.delete();
      end else begin
         chk("done_seen", 32'(fin), 32'd1);
         chk("act_len", 32'(act_cnt), 32'(exp_len));
         chk("done_cnt", 32'(done_cnt), 32'd1);
         chk("done_active", 32'(dma_active), 32'd0);
         chk("rdq_left", 32'(rdq.size()), 32'd0);
         chk("wq_left", 32'(wq.size()), 32'd0);
         cyc();
         chk("done_pulse", 32'(dma_done), 32'd0);
         rdq.delete();
         wq.delete();
      end
   endtask

   initial begin
      RESET = 1'b1;
      repeat (3) cyc();
      RESET = 1'b0;
      chk_quiet("reset");
      cyc();
      chk_quiet("idle");
      // Odd alignment: HALT with par = 1 -> 513 active cycles.
      xfer(8'h02, 1'b1, 513, 0, -1, 1'b0);
      // Even alignment: one ALIGN cycle -> 514.
      xfer(8'h02, 1'b0, 514, 0, -1, 1'b0);
      // Page $FF: reads stop at $FFFF.
      xfer(8'hFF, 1'b1, 513, 0, -1, 1'b0);
      // Stray trigger write while active is ignored.
      xfer(8'h05, 1'b0, 514, 100, -1, 1'b0);
      // Reset during WRITE of byte 40, then a fresh transfer from count 0.
      xfer(8'h09, 1'b1, 513, 0, 40, 1'b0);
      xfer(8'h0A, 1'b0, 514, 0, -1, 1'b0);
      // ENABLE freeze mid-READ for 10 cycles.
      xfer(8'h0C, 1'b1, 513, 0, -1, 1'b1);
      xfer(8'h0D, 1'b0, 514, 0, -1, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Sequencer for the $4014 sprite DMA transfer on the CPU bus. It detects the CPU write to the trigger address and latches the source page. It then halts the CPU and runs 256 alternating read/write cycles, with cycle-parity alignment, copying CPU-bus memory at {page, $00..$FF} into PPU OAM. It sits beside the CPU bus mux. Its dma_active output drives both the bus mux and the CPU enable gating, and its OAM outputs feed the PPU DMA write port.

## Interface
- TRIGGER_ADDR, 16'h4014, CPU address whose write starts a transfer.
- CLK  in  1  CPU clock; the block's only clock.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  clock enable. When low, all state, including the parity flop, holds.
- cpu_addr  in  16  CPU address output.
- cpu_data_out  in  8  CPU write data.
- cpu_rw_n  in  1  1 = read, 0 = write.
- mem_data_in  in  8  read data from the CPU-bus memory mux. Synchronous, 1-cycle latency.
- dma_active  out  1  high in every non-IDLE state. Halts the CPU and gives the bus to DMA.
- dma_addr  out  16  bus address while DMA owns the bus.
- dma_rden  out  1  memory read strobe.
- oam_wren  out  1  OAM write strobe.
- oam_addr  out  8  OAM byte index.
- oam_data  out  8  OAM write data. Combinational copy of mem_data_in.
- dma_done  out  1  one-cycle pulse after the final OAM write.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Parity flop `par` toggles on every enabled CLK edge. It resets to 0. READ cycles occur only while par = 0.
- IDLE:
  - Trigger condition: ENABLE & ~cpu_rw_n & (cpu_addr == TRIGGER_ADDR).
  - On trigger, latch page <= cpu_data_out, clear count <= 0, and go to HALT.
- HALT: one cycle.
  - If par = 1 in this cycle, go to READ (the next cycle has par = 0). Total length is 513 cycles.
  - Otherwise go to ALIGN. Total length is 514 cycles.
- ALIGN: one cycle, no strobes, then READ.
- READ:
  - dma_addr = {page, count}, dma_rden = 1.
  - Next state is WRITE.
- WRITE:
  - oam_wren = 1, oam_addr = count, oam_data = mem_data_in (the data read in the preceding READ).
  - If count == 8'hFF: go to IDLE and assert dma_done in the following cycle.
  - Else: count <= count + 1 and go to READ.
- count is 8 bits.
  - The source address never carries into the page byte. Page $FF reads $FF00..$FFFF only.
  - No wrap to $0000 occurs.
- A trigger-address write seen while not IDLE is ignored. page and count are unchanged.
- Outside READ: dma_addr = 16'h0000 and dma_rden = 0. Outside WRITE: oam_wren = 0 and oam_addr = 0.
- Reset values:
  - state = IDLE, par = 0, page = 0, count = 0.
  - All outputs are 0.
- Reset mid-transfer: the next cycle is IDLE with all outputs 0. No further OAM writes occur, and dma_done is not pulsed.

## Timing
- The trigger is sampled at edge E0 (the end of the CPU write cycle). dma_active is high from the cycle after E0.
- First READ is 1 cycle after HALT (par = 1 in HALT) or 2 cycles after HALT (par = 0 in HALT).
- Strobe sequence: READ/WRITE pairs; byte n is written exactly 1 cycle after its read.
- dma_active stays high through the final WRITE. It drops in the same cycle dma_done is high.
- The CPU may re-trigger in the first cycle dma_done is high; that trigger is accepted.
- ENABLE low stretches any state indefinitely.
  - Strobes stay asserted combinationally for the current state while frozen.
  - Consumers must qualify them with ENABLE.

## Test plan
- Odd alignment:
  - Stimulus: reset; time the write of $02 to $4014 so that HALT has par = 1.
  - Response:
    - dma_active high for 513 cycles.
    - Reads at $0200..$02FF.
    - oam_addr 0..255 with oam_data equal to a memory model pattern (addr ^ $5A).
    - One dma_done pulse.
- Even alignment: same as above with HALT at par = 0 -> exactly one ALIGN cycle and 514 active cycles.
- Page $FF: write $FF -> last read is $FFFF, then dma_done. No access at $0000.
- Re-trigger while active: write $07 to $4014 at the 100th active cycle -> page stays at the original value, and length and addresses are unchanged.
- Reset at byte 40: RESET during a WRITE of count = 40 -> the next cycle is IDLE with all outputs 0, no dma_done, and a fresh trigger afterwards starts at count 0.
- ENABLE freeze: hold ENABLE low for 10 cycles mid-READ -> state, count, and par unchanged. Total active enabled cycles are still 513 or 514.
